// File: rtl/stb_delay_sweep.sv
// Equivalent-time strobe delay sweep: replays each strobe edge after delay D, stepping D by S every N hits until D+S >= P.
// dstb_o lands 1+D cycles after the edge; no backpressure, edges arriving while a delay is pending are dropped and flagged on err_o.
module stb_delay_sweep #(
  parameter int T_CNT_WIDTH   = 32,
  parameter int HIT_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     stb_i,
  input  logic                     period_vld_i,
  input  logic [T_CNT_WIDTH-1:0]   stb_period_i,
  input  logic                     start_i,
  input  logic [T_CNT_WIDTH-1:0]   step_i,
  input  logic [HIT_CNT_WIDTH-1:0] hits_i,
  output logic                     dstb_o,
  output logic [T_CNT_WIDTH-1:0]   delay_o,
  output logic                     step_done_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q;
  logic                     stb_prev;
  logic [T_CNT_WIDTH-1:0]   period_q;
  logic [T_CNT_WIDTH-1:0]   step_q;
  logic [HIT_CNT_WIDTH-1:0] hits_q;
  logic [HIT_CNT_WIDTH-1:0] hit_cnt;
  logic [T_CNT_WIDTH-1:0]   dly_cnt;

  logic                     stb_edge;
  logic                     start_ok;
  logic                     acct;
  logic [HIT_CNT_WIDTH-1:0] hit_inc;
  logic                     hit_full;
  logic [HIT_CNT_WIDTH-1:0] hit_nxt;
  logic                     step_nxt;
  logic [T_CNT_WIDTH:0]     d_sum;
  logic                     sweep_end;
  logic                     leave_run;

  always_comb begin
    stb_edge  = stb_i & ~stb_prev;
    start_ok  = period_vld_i && (stb_period_i != '0) && (step_i != '0);
    // hit accounting happens in the cycle the delayed strobe is visible
    acct      = (state_q == RUN) && dstb_o;
    hit_inc   = hit_cnt + HIT_CNT_WIDTH'(1);
    hit_full  = (hit_inc == hits_q);
    hit_nxt   = acct ? (hit_full ? '0 : hit_inc) : hit_cnt;
    step_nxt  = ((hit_nxt + HIT_CNT_WIDTH'(1)) == hits_q);
    d_sum     = {1'b0, delay_o} + {1'b0, step_q};
    sweep_end = (d_sum >= {1'b0, period_q});
    leave_run = acct && hit_full && sweep_end;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      stb_prev    <= 1'b0;
      period_q    <= '0;
      step_q      <= '0;
      hits_q      <= '0;
      hit_cnt     <= '0;
      dly_cnt     <= '0;
      dstb_o      <= 1'b0;
      delay_o     <= '0;
      step_done_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      stb_prev    <= stb_i;
      dstb_o      <= 1'b0;
      step_done_o <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            if (start_ok) begin
              period_q <= stb_period_i;
              step_q   <= step_i;
              hits_q   <= (hits_i == '0) ? HIT_CNT_WIDTH'(1) : hits_i;
              delay_o  <= '0;
              hit_cnt  <= '0;
              dly_cnt  <= '0;
              err_o    <= 1'b0;
              done_o   <= 1'b0;
              busy_o   <= 1'b1;
              state_q  <= RUN;
            end else begin
              err_o    <= 1'b1;
              done_o   <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        RUN: begin
          if (!period_vld_i) begin
            state_q <= IDLE;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            dly_cnt <= '0;
          end else begin
            if (acct) begin
              hit_cnt <= hit_nxt;
              if (hit_full && !sweep_end) begin
                delay_o <= d_sum[T_CNT_WIDTH-1:0];
              end
            end
            if (leave_run) begin
              // delay_o keeps the last delay point actually used
              state_q <= DONE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              dly_cnt <= '0;
            end else if (dly_cnt != '0) begin
              dly_cnt <= dly_cnt - T_CNT_WIDTH'(1);
              if (dly_cnt == T_CNT_WIDTH'(1)) begin
                dstb_o      <= 1'b1;
                step_done_o <= step_nxt;
              end
              if (stb_edge) begin
                err_o <= 1'b1;
              end
            end else if (stb_edge) begin
              // an edge sees the delay point in force before any update this cycle
              if (delay_o == '0) begin
                dstb_o      <= 1'b1;
                step_done_o <= step_nxt;
              end else begin
                dly_cnt <= delay_o;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stb_delay_sweep.md
Name: stb_delay_sweep

Overview:
- Sits directly downstream of the strobe generator in the measure unit.
- Consumes its per-period strobe and measured period (in clk ticks) and emits a delayed copy of the strobe.
- Sweeps the delay from 0 up to one period in programmable steps, holding each delay point for a programmable number of strobes, so the comparator can be sampled at equivalent-time offsets across the measured signal period.

Parameters:
- T_CNT_WIDTH, 32, width of period, delay and step values in clk ticks
- HIT_CNT_WIDTH, 16, width of the strobes-per-step count

Ports:
- clk_i  in  1  system clock
- arst_ni  in  1  reset; one clock, reset is asynchronous and active-low
- stb_i  in  1  strobe from strobe generator; level, rising edge used
- period_vld_i  in  1  high while stb_period_i is valid (strobe generator ready)
- stb_period_i  in  T_CNT_WIDTH  measured period P in clk ticks
- start_i  in  1  single-cycle pulse, starts a sweep
- step_i  in  T_CNT_WIDTH  delay increment S per point
- hits_i  in  HIT_CNT_WIDTH  strobes per delay point N
- dstb_o  out  1  delayed strobe, single-cycle pulse
- delay_o  out  T_CNT_WIDTH  current delay D
- step_done_o  out  1  single-cycle pulse when a delay point completes
- busy_o  out  1  sweep in progress
- done_o  out  1  sweep finished; held until next start or reset
- err_o  out  1  sticky error flag; cleared by an accepted start or reset

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal counters 0, stb_i edge register 0.
- Edge detect: stb_prev is stb_i registered. An edge occurs in cycle k when stb_i=1 and stb_prev=0.
- FSM states are IDLE, RUN and DONE.
- IDLE/DONE, on start_i:
  - Preconditions: period_vld_i=1, P!=0, S!=0.
  - If all hold: latch P, S and N (N=0 treated as 1); set D=0 and hit count 0; clear err_o and done_o; go to RUN; busy_o=1 from the next cycle.
  - If any fails: set err_o, stay in or go to IDLE, done_o=0.
- start_i while in RUN is ignored.
- RUN, on an edge at cycle k with no delay pending:
  - Load the delay counter with the current D.
  - dstb_o=1 in exactly cycle k+1+D (D=0 gives a pulse in k+1).
  - Exactly one pulse per accepted edge.
- RUN, edge while a delay is still pending: ignore the edge (no reload, no extra pulse) and set err_o.
- Hit accounting occurs in the cycle dstb_o fires; the hit count increments.
  - When the count reaches N in that cycle: step_done_o=1, count clears, D_next = D+S.
  - Compute D+S in T_CNT_WIDTH+1 bits.
  - If D+S >= P: go to DONE the next cycle, busy_o=0, done_o=1, delay_o holds the last used D.
  - Otherwise D=D+S, effective from the next edge.
- The delay applied to an edge is the D value at the cycle of that edge.
- period_vld_i falls in RUN:
  - Abort to IDLE and set err_o.
  - Any pending dstb_o is cancelled; busy_o=0, done_o=0.
- Simultaneous edge and hit-complete in the same cycle: the edge uses the old D, since the pending check sees the counter at 0 after firing.
- Asynchronous reset mid-sweep returns to reset values immediately; no dstb_o pulse after reset.
- Latched P, S and N are not affected by input changes during RUN.

Test Plan:
- P=10, S=3, N=2, edges every 10 cycles -> delays 0,0,3,3,6,6,9,9. dstb_o lands 1,1,4,4,7,7,10,10 cycles after each edge. 4 step_done_o pulses. done_o=1 after the 8th pulse, busy_o=0, delay_o=9.
- P=8, S=8, N=1 -> one dstb_o at edge+1, then DONE (0+8>=8).
- start_i with S=0, or with period_vld_i=0 -> err_o=1, FSM stays IDLE, no dstb_o. A following valid start clears err_o.
- P=10, S=4, stb_i edges 6 cycles apart at D=8 -> second edge ignored, err_o=1, only one dstb_o.
- Drop period_vld_i while a pulse is pending at D=6 -> no dstb_o, busy_o=0, err_o=1, FSM in IDLE.
- Assert arst_ni low mid-sweep with delay pending -> all outputs 0 immediately, no dstb_o afterwards until a new start_i.
